// File: rtl/ctrl_pkg.sv
// Shared control-path types for the 5-stage core: opcodes, ALU-op codes, the per-stage
// control bundle and the source/destination match helper used by hazard detection.
package ctrl_pkg;

  localparam int CTRL_RA_MAX_W = 8;

  localparam int OP_RT   = 0;
  localparam int OP_ADDI = 1;
  localparam int OP_SLTI = 2;
  localparam int OP_LW   = 3;
  localparam int OP_SW   = 4;
  localparam int OP_BEQ  = 5;
  localparam int OP_J    = 6;
  localparam int OP_JR   = 7;
  localparam int OP_JAL  = 8;
  localparam int OP_BNE  = 9;

  localparam logic [1:0] ALU_RT  = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b01;
  localparam logic [1:0] ALU_SLT = 2'b10;
  localparam logic [1:0] ALU_BR  = 2'b11;

  // dst is sized for the widest supported register file; narrower files zero-extend
  typedef struct packed {
    logic                     reg_dst;
    logic                     alu_src;
    logic [1:0]               alu_op;
    logic                     mem_read;
    logic                     mem_write;
    logic                     mem_to_reg;
    logic                     reg_write;
    logic                     jal;
    logic [CTRL_RA_MAX_W-1:0] dst;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_NOP = '0;

  function automatic logic src_hit(input logic [CTRL_RA_MAX_W-1:0] dst,
                                   input logic [CTRL_RA_MAX_W-1:0] rs,
                                   input logic [CTRL_RA_MAX_W-1:0] rt,
                                   input logic use_rs, input logic use_rt);
    return (dst != '0) && ((use_rs && dst == rs) || (use_rt && dst == rt));
  endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational opcode decoder: control bundle, redirect bits and source-use flags.
// Define CTRL_BNE_EN to decode opcode 9 as BNE; otherwise it is a NOP.
module ctrl_decoder #(
  parameter int OPC_W = 6,
  parameter int RA_W  = 5
) (
  input  logic [OPC_W-1:0]           opc,
  input  logic                       eq,
  input  logic [RA_W-1:0]            id_rt,
  input  logic [RA_W-1:0]            id_rd,
  output ctrl_pkg::ctrl_bundle_t     bundle,
  output logic                       pcsrc,
  output logic                       jmp,
  output logic                       jr,
  output logic                       flush,
  output logic                       use_rs,
  output logic                       use_rt,
  output logic                       is_br
);
  import ctrl_pkg::*;

  localparam logic [CTRL_RA_MAX_W-1:0] LINK_REG = CTRL_RA_MAX_W'({RA_W{1'b1}});

  logic valid;

  always_comb begin
    bundle = CTRL_NOP;
    pcsrc  = 1'b0;
    jmp    = 1'b0;
    jr     = 1'b0;
    flush  = 1'b0;
    use_rs = 1'b1;
    use_rt = 1'b0;
    is_br  = 1'b0;
    valid  = 1'b1;
    case (opc)
      OPC_W'(OP_RT): begin
        bundle.reg_dst   = 1'b1;
        bundle.reg_write = 1'b1;
        bundle.alu_op    = ALU_RT;
        use_rt           = 1'b1;
      end
      OPC_W'(OP_ADDI), OPC_W'(OP_SLTI): begin
        bundle.alu_src   = 1'b1;
        bundle.reg_write = 1'b1;
        bundle.alu_op    = (opc == OPC_W'(OP_SLTI)) ? ALU_SLT : ALU_ADD;
      end
      OPC_W'(OP_LW): begin
        bundle.alu_src    = 1'b1;
        bundle.mem_read   = 1'b1;
        bundle.mem_to_reg = 1'b1;
        bundle.reg_write  = 1'b1;
        bundle.alu_op     = ALU_ADD;
      end
      OPC_W'(OP_SW): begin
        bundle.alu_src   = 1'b1;
        bundle.mem_write = 1'b1;
        bundle.alu_op    = ALU_ADD;
        use_rt           = 1'b1;
      end
      OPC_W'(OP_BEQ): begin
        bundle.alu_op = ALU_BR;
        pcsrc         = eq;
        flush         = eq;
        use_rt        = 1'b1;
        is_br         = 1'b1;
      end
      OPC_W'(OP_J): begin
        jmp    = 1'b1;
        flush  = 1'b1;
        use_rs = 1'b0;
      end
      OPC_W'(OP_JR): begin
        jr    = 1'b1;
        flush = 1'b1;
        is_br = 1'b1;
      end
      OPC_W'(OP_JAL): begin
        bundle.jal       = 1'b1;
        bundle.reg_write = 1'b1;
        jmp              = 1'b1;
        flush            = 1'b1;
        use_rs           = 1'b0;
      end
`ifdef CTRL_BNE_EN
      OPC_W'(OP_BNE): begin
        bundle.alu_op = ALU_BR;
        pcsrc         = ~eq;
        flush         = ~eq;
        use_rt        = 1'b1;
        is_br         = 1'b1;
      end
`endif
      default: begin
        use_rs = 1'b0;
        valid  = 1'b0;
      end
    endcase
    // unknown opcodes keep an all-zero bundle, including dst
    if (valid) begin
      bundle.dst = bundle.jal ? LINK_REG :
                   (bundle.reg_dst ? CTRL_RA_MAX_W'(id_rd) : CTRL_RA_MAX_W'(id_rt));
    end
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control/hazard unit: ID decode, ID/EX-EX/MEM-MEM/WB control registers,
// load-use and branch-source stalls, mem_stall freeze. CTRL_BNE_EN enables BNE (opcode 9).
module pipe_ctrl_unit #(
  parameter int OPC_W   = 6,
  parameter int RA_W    = 5,
  parameter int ALUOP_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OPC_W-1:0]   opc,
  input  logic               eq,
  input  logic [RA_W-1:0]    id_rs,
  input  logic [RA_W-1:0]    id_rt,
  input  logic [RA_W-1:0]    id_rd,
  input  logic               mem_stall,
  output logic               pc_write,
  output logic               ifid_write,
  output logic               if_flush,
  output logic               pcsrc,
  output logic               jmp,
  output logic               jr,
  output logic               ex_reg_dst,
  output logic               ex_alu_src,
  output logic               ex_jal,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               mem_read,
  output logic               mem_write,
  output logic               wb_reg_write,
  output logic               wb_mem_to_reg,
  output logic               wb_jal,
  output logic [RA_W-1:0]    wb_dst
);
  import ctrl_pkg::*;

  ctrl_bundle_t dec, ex_q, mem_q, wb_q;
  logic dec_pcsrc, dec_jmp, dec_jr, dec_flush;
  logic use_rs, use_rt, is_br;
  logic hz_load, hz_br, stall, go;
  logic [CTRL_RA_MAX_W-1:0] rs_x, rt_x;

  ctrl_decoder #(.OPC_W(OPC_W), .RA_W(RA_W)) u_dec (
    .opc    (opc),
    .eq     (eq),
    .id_rt  (id_rt),
    .id_rd  (id_rd),
    .bundle (dec),
    .pcsrc  (dec_pcsrc),
    .jmp    (dec_jmp),
    .jr     (dec_jr),
    .flush  (dec_flush),
    .use_rs (use_rs),
    .use_rt (use_rt),
    .is_br  (is_br)
  );

  assign rs_x = CTRL_RA_MAX_W'(id_rs);
  assign rt_x = CTRL_RA_MAX_W'(id_rt);

  // branch/JR compare in ID, so a producer in EX or a load in MEM must drain first
  assign hz_load = ex_q.mem_read && src_hit(ex_q.dst, rs_x, rt_x, use_rs, use_rt);
  assign hz_br   = is_br &&
                   ((ex_q.reg_write && src_hit(ex_q.dst, rs_x, rt_x, use_rs, use_rt)) ||
                    (mem_q.mem_read && src_hit(mem_q.dst, rs_x, rt_x, use_rs, use_rt)));
  assign stall   = hz_load | hz_br;
  assign go      = ~mem_stall & ~stall;

  assign pc_write   = go;
  assign ifid_write = go;
  assign pcsrc      = go & dec_pcsrc;
  assign jmp        = go & dec_jmp;
  assign jr         = go & dec_jr;
  assign if_flush   = go & dec_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= CTRL_NOP;
      mem_q <= CTRL_NOP;
      wb_q  <= CTRL_NOP;
    end else if (!mem_stall) begin
      ex_q  <= stall ? CTRL_NOP : dec;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  assign ex_reg_dst    = ex_q.reg_dst;
  assign ex_alu_src    = ex_q.alu_src;
  assign ex_jal        = ex_q.jal;
  assign ex_alu_op     = ALUOP_W'(ex_q.alu_op);
  assign mem_read      = mem_q.mem_read;
  assign mem_write     = mem_q.mem_write;
  assign wb_reg_write  = wb_q.reg_write;
  assign wb_mem_to_reg = wb_q.mem_to_reg;
  assign wb_jal        = wb_q.jal;
  assign wb_dst        = RA_W'(wb_q.dst);

  logic unused_wb;
  assign unused_wb = ^{wb_q.reg_dst, wb_q.alu_src, wb_q.alu_op, wb_q.mem_read,
                       wb_q.mem_write, wb_q.dst};

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: directed hazard sequences then random instructions, checked
// against an instruction-level pipeline model. Follows CTRL_BNE_EN like the RTL.
module tb_pipe_ctrl_unit;
  localparam int OPC_W   = 6;
  localparam int RA_W    = 5;
  localparam int ALUOP_W = 2;
`ifdef CTRL_BNE_EN
  localparam bit BNE_ON = 1'b1;
`else
  localparam bit BNE_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, eq, mem_stall;
  logic [OPC_W-1:0] opc;
  logic [RA_W-1:0] id_rs, id_rt, id_rd;
  logic pc_write, ifid_write, if_flush, pcsrc, jmp, jr;
  logic ex_reg_dst, ex_alu_src, ex_jal;
  logic [ALUOP_W-1:0] ex_alu_op;
  logic mem_read, mem_write, wb_reg_write, wb_mem_to_reg, wb_jal;
  logic [RA_W-1:0] wb_dst;

  pipe_ctrl_unit #(.OPC_W(OPC_W), .RA_W(RA_W), .ALUOP_W(ALUOP_W)) dut (
    .clk(clk), .rst(rst), .opc(opc), .eq(eq), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .mem_stall(mem_stall), .pc_write(pc_write), .ifid_write(ifid_write), .if_flush(if_flush),
    .pcsrc(pcsrc), .jmp(jmp), .jr(jr), .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src),
    .ex_jal(ex_jal), .ex_alu_op(ex_alu_op), .mem_read(mem_read), .mem_write(mem_write),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_jal(wb_jal),
    .wb_dst(wb_dst)
  );

  always #5 clk = ~clk;

  typedef struct { int op; int rs; int rt; int rd; } ins_t;
  ins_t m_ex, m_mem, m_wb;
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic ins_t nop_ins();
    ins_t i;
    i.op = -1; i.rs = 0; i.rt = 0; i.rd = 0;
    return i;
  endfunction

  function automatic bit known(int op);
    return (op >= 0 && op <= 8) || (BNE_ON && op == 9);
  endfunction
  function automatic bit is_bne(int op);
    return BNE_ON && op == 9;
  endfunction
  function automatic bit writes(int op);
    return op == 0 || op == 1 || op == 2 || op == 3 || op == 8;
  endfunction
  function automatic int dest(ins_t i);
    if (!known(i.op)) return 0;
    if (i.op == 8) return 31;
    return (i.op == 0) ? i.rd : i.rt;
  endfunction
  function automatic bit reads(ins_t i, int r);
    bit urs, urt;
    urs = known(i.op) && i.op != 6 && i.op != 8;
    urt = i.op == 0 || i.op == 4 || i.op == 5 || is_bne(i.op);
    return r != 0 && ((urs && i.rs == r) || (urt && i.rt == r));
  endfunction
  function automatic int alu_of(int op);
    if (op == 1 || op == 3 || op == 4) return 1;
    if (op == 2) return 2;
    if (op == 5 || is_bne(op)) return 3;
    return 0;
  endfunction

  task automatic step(input int op, input int rs, input int rt, input int rd,
                      input bit e, input bit ms, input bit r);
    ins_t id;
    bit stall, go, take;
    @(negedge clk);
    opc = OPC_W'(op); id_rs = RA_W'(rs); id_rt = RA_W'(rt); id_rd = RA_W'(rd);
    eq = e; mem_stall = ms; rst = r;
    id.op = op; id.rs = rs; id.rt = rt; id.rd = rd;
    stall = (m_ex.op == 3 && reads(id, dest(m_ex))) ||
            ((op == 5 || op == 7 || is_bne(op)) &&
             ((writes(m_ex.op) && reads(id, dest(m_ex))) ||
              (m_mem.op == 3 && reads(id, dest(m_mem)))));
    go   = !ms && !stall;
    take = (op == 5 && e) || (is_bne(op) && !e);
    #1;
    chk("pc_write", pc_write, go);
    chk("ifid_write", ifid_write, go);
    chk("pcsrc", pcsrc, go && take);
    chk("jmp", jmp, go && (op == 6 || op == 8));
    chk("jr", jr, go && op == 7);
    chk("if_flush", if_flush, go && (take || op == 6 || op == 7 || op == 8));
    chk("ex_reg_dst", ex_reg_dst, m_ex.op == 0);
    chk("ex_alu_src", ex_alu_src, m_ex.op >= 1 && m_ex.op <= 4);
    chk("ex_alu_op", ex_alu_op, alu_of(m_ex.op));
    chk("ex_jal", ex_jal, m_ex.op == 8);
    chk("mem_read", mem_read, m_mem.op == 3);
    chk("mem_write", mem_write, m_mem.op == 4);
    chk("wb_reg_write", wb_reg_write, writes(m_wb.op));
    chk("wb_mem_to_reg", wb_mem_to_reg, m_wb.op == 3);
    chk("wb_jal", wb_jal, m_wb.op == 8);
    chk("wb_dst", wb_dst, dest(m_wb));
    @(posedge clk);
    cyc++;
    if (r) begin
      m_ex = nop_ins(); m_mem = nop_ins(); m_wb = nop_ins();
    end else if (!ms) begin
      m_wb  = m_mem;
      m_mem = m_ex;
      m_ex  = stall ? nop_ins() : id;
    end
  endtask

  task automatic nops(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; opc = '0; eq = 1'b0; mem_stall = 1'b0;
    id_rs = '0; id_rt = '0; id_rd = '0;
    m_ex = nop_ins(); m_mem = nop_ins(); m_wb = nop_ins();
    repeat (2) @(posedge clk);
    nops(1);
    // load-use: LW r2 then RT with rs=2, held in ID while stalled
    step(3, 1, 2, 0, 0, 0, 0);
    step(0, 2, 5, 6, 0, 0, 0);
    step(0, 2, 5, 6, 0, 0, 0);
    nops(3);
    // ADDI r3 then BEQ rs=3 taken
    step(1, 0, 3, 0, 0, 0, 0);
    step(5, 3, 0, 0, 1, 0, 0);
    step(5, 3, 0, 0, 1, 0, 0);
    nops(3);
    // LW r4 then JR r4: two stall cycles
    step(3, 0, 4, 0, 0, 0, 0);
    repeat (3) step(7, 4, 0, 0, 0, 0, 0);
    nops(3);
    // mem_stall with a load in MEM
    step(3, 0, 6, 0, 0, 0, 0);
    step(1, 1, 7, 0, 0, 0, 0);
    repeat (3) step(1, 1, 7, 0, 0, 1, 0);
    nops(4);
    // JAL and opcode 9
    step(8, 0, 0, 0, 0, 0, 0);
    nops(3);
    step(9, 1, 2, 0, 0, 0, 0);
    nops(3);
    // reset asserted while a load-use stall is pending
    step(3, 0, 2, 0, 0, 0, 0);
    step(0, 2, 0, 1, 0, 0, 1);
    nops(2);
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 11), $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 3), 1'($urandom_range(0, 1)),
           $urandom_range(0, 5) == 0, $urandom_range(0, 63) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
